// File: rtl/sort_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sort_stream_ctrl
// Description : Collects a frame of 4-bit elements, hands it to an external
//               quicksort stage and streams the sorted result out.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_stream_ctrl #(
  parameter int ARR_WIDTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [ARR_WIDTH*4-1:0] sort_array,
  output logic                   sort_enable,
  output logic [3:0]             sort_hi_ind,
  output logic [3:0]             sort_lo_ind,
  input  logic                   sort_valid,
  input  logic [ARR_WIDTH*4-1:0] sort_result,
  output logic [3:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [15:0]            sort_cycles
);

  localparam logic [3:0] c_last_idx = 4'(ARR_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_SORT    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_rd;
  logic [3:0]  r_buf [ARR_WIDTH];
  logic [15:0] r_cyc;
  logic [15:0] r_sort_cycles;
  logic        w_in_fire;
  logic        w_in_close;
  logic        w_out_fire;
  logic        w_out_last;
  logic [3:0]  w_out_data;

  assign in_ready    = reset && (r_state == ST_COLLECT);
  assign w_in_fire   = in_valid && in_ready;
  assign w_in_close  = w_in_fire && (in_last || (r_cnt == c_last_idx));
  assign out_valid   = (r_state == ST_DRAIN);
  assign w_out_last  = out_valid && (r_rd == r_cnt - 4'd1);
  assign w_out_fire  = out_valid && out_ready;
  assign out_last    = w_out_last;
  assign out_data    = w_out_data;
  assign sort_enable = (r_state == ST_SORT);
  assign sort_hi_ind = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
  assign sort_lo_ind = 4'd0;
  assign sort_cycles = r_sort_cycles;

  // Slots beyond the frame length stay cleared, so unused lanes read as 0.
  for (genvar gi = 0; gi < ARR_WIDTH; gi++) begin : g_pack
    assign sort_array[(ARR_WIDTH-gi)*4-1 -: 4] = r_buf[gi];
  end

  always_comb begin
    w_out_data = 4'd0;
    if (r_state == ST_DRAIN) begin
      for (int i = 0; i < ARR_WIDTH; i++) begin
        if (r_rd == 4'(i)) w_out_data = r_buf[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_COLLECT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_COLLECT: if (w_in_close) w_next_state = (r_cnt == 4'd0) ? ST_DRAIN : ST_SORT;
      ST_SORT:    if (sort_valid) w_next_state = ST_RELEASE;
      ST_RELEASE: if (!sort_valid) w_next_state = ST_DRAIN;
      ST_DRAIN:   if (w_out_fire && w_out_last) w_next_state = ST_COLLECT;
      default:    w_next_state = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_cnt         <= 4'd0;
      r_rd          <= 4'd0;
      r_cyc         <= 16'd0;
      r_sort_cycles <= 16'd0;
      for (int i = 0; i < ARR_WIDTH; i++) r_buf[i] <= 4'd0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_in_fire) begin
            for (int i = 0; i < ARR_WIDTH; i++) begin
              if (r_cnt == 4'(i)) r_buf[i] <= in_data;
            end
            r_cnt <= r_cnt + 4'd1;
          end
          // The first SORT cycle already counts as cycle 1.
          if (w_in_close) r_cyc <= 16'd1;
        end
        ST_SORT: begin
          if (sort_valid) begin
            for (int i = 0; i < ARR_WIDTH; i++) begin
              if (4'(i) < r_cnt) r_buf[i] <= sort_result[(ARR_WIDTH-i)*4-1 -: 4];
            end
            r_sort_cycles <= r_cyc;
          end else if (r_cyc != 16'hFFFF) begin
            r_cyc <= r_cyc + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (w_out_fire) begin
            if (w_out_last) begin
              r_cnt <= 4'd0;
              r_rd  <= 4'd0;
              for (int i = 0; i < ARR_WIDTH; i++) r_buf[i] <= 4'd0;
            end else begin
              r_rd <= r_rd + 4'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
